// File: rtl/mips_debug_frame_server.sv
// mips_debug_frame_server
// MIPS-side responder of the debug request channel. A one-cycle request code
// selects a register, the PC, a data/instruction memory word or a pipeline
// latch group. The block fetches it and streams it back as NB_REG-bit frames,
// most-significant word first, then emits a one-cycle end-of-data strobe.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_request_select        request code, 6'b111111 = no request
//   i_mem_addr              memory address accompanying a memory request
//   i_latch_bus             8 latch groups, group k at [(k+1)*NB_LATCH-1 -: NB_LATCH]
//   i_pc                    current PC
//   o_reg_addr/i_reg_data   regfile read port
//   o_data_mem_addr/i_data_mem_data    data memory read port
//   o_instr_mem_addr/i_instr_mem_data  instruction memory read port
//   o_frame, o_frame_valid  payload word and its qualifier
//   o_eod                   one-cycle end-of-data strobe
//   o_busy                  request in progress
module mips_debug_frame_server #(
    parameter int NB_REG        = 32,
    parameter int NB_ADDR_DATA  = 16,
    parameter int NB_INSTR_ADDR = 9,
    parameter int NB_LATCH      = 96,
    parameter int RD_LATENCY    = 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [5:0]                i_request_select,
    input  logic [NB_ADDR_DATA-1:0]   i_mem_addr,
    input  logic [8*NB_LATCH-1:0]     i_latch_bus,
    input  logic [NB_REG-1:0]         i_pc,
    output logic [4:0]                o_reg_addr,
    input  logic [NB_REG-1:0]         i_reg_data,
    output logic [NB_ADDR_DATA-1:0]   o_data_mem_addr,
    input  logic [NB_REG-1:0]         i_data_mem_data,
    output logic [NB_INSTR_ADDR-1:0]  o_instr_mem_addr,
    input  logic [NB_REG-1:0]         i_instr_mem_data,
    output logic [NB_REG-1:0]         o_frame,
    output logic                      o_frame_valid,
    output logic                      o_eod,
    output logic                      o_busy
);

    localparam int N_WORDS = NB_LATCH / NB_REG;
    localparam int NB_CNT  = $clog2(N_WORDS + 1);
    localparam int NB_WAIT = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [NB_WAIT-1:0] WAIT_LAST = NB_WAIT'(RD_LATENCY - 1);
    localparam logic [5:0] CODE_NONE        = 6'b111111;
    localparam logic [5:0] CODE_DMEM        = 6'b100000;
    localparam logic [5:0] CODE_IMEM        = 6'b100001;
    localparam logic [5:0] CODE_PC          = 6'b100010;
    localparam logic [5:0] CODE_LATCH_FIRST = 6'b100100;
    localparam logic [5:0] CODE_LATCH_LAST  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                     state_r;
    logic [5:0]                 code_r;
    logic [4:0]                 reg_addr_r;
    logic [NB_ADDR_DATA-1:0]    dmem_addr_r;
    logic [NB_INSTR_ADDR-1:0]   imem_addr_r;
    logic [NB_LATCH-1:0]        snap_r;
    logic                       from_snap_r;
    logic [NB_LATCH-1:0]        shift_r;
    logic [NB_CNT-1:0]          words_r;
    logic [NB_CNT-1:0]          cnt_r;
    logic [NB_WAIT-1:0]         wait_r;

    logic                       accept_s;
    logic                       is_latch_s;
    logic [2:0]                 latch_idx_s;
    logic [NB_LATCH-1:0]        snap_sel_s;
    logic [NB_REG-1:0]          load_word_s;
    logic [NB_LATCH-1:0]        load_s;
    logic [NB_LATCH-1:0]        shifted_s;
    logic [NB_CNT-1:0]          cnt_next_s;

    // Number of payload words for a request code; 0 marks an invalid code.
    function automatic logic [NB_CNT-1:0] payload_words(input logic [5:0] code);
        logic [NB_CNT-1:0] words;
        if (!code[5]) begin
            words = NB_CNT'(1);
        end else if (code == CODE_DMEM || code == CODE_IMEM || code == CODE_PC) begin
            words = NB_CNT'(1);
        end else if (code >= CODE_LATCH_FIRST && code <= CODE_LATCH_LAST) begin
            words = NB_CNT'(N_WORDS);
        end else begin
            words = {NB_CNT{1'b0}};
        end
        return words;
    endfunction

    assign accept_s    = (state_r == IDLE) && !i_reset && (i_request_select != CODE_NONE);
    assign is_latch_s  = (i_request_select >= CODE_LATCH_FIRST) && (i_request_select <= CODE_LATCH_LAST);
    // Codes 36..43 have low bits 4,5,6,7,0,1,2,3, so k = low3 - 4 (mod 8).
    assign latch_idx_s = i_request_select[2:0] - 3'd4;

    // Address outputs track the incoming request while idle, then hold.
    assign o_reg_addr       = accept_s ? i_request_select[4:0] : reg_addr_r;
    assign o_data_mem_addr  = accept_s ? i_mem_addr : dmem_addr_r;
    assign o_instr_mem_addr = accept_s ? i_mem_addr[NB_INSTR_ADDR-1:0] : imem_addr_r;

    // Source selection for the snapshot and for the shift-register load.
    always_comb begin
        snap_sel_s  = NB_LATCH'(i_pc) << (NB_LATCH - NB_REG);
        load_word_s = {NB_REG{1'b0}};
        if (is_latch_s) begin
            snap_sel_s = i_latch_bus[latch_idx_s*NB_LATCH +: NB_LATCH];
        end else begin
            snap_sel_s = NB_LATCH'(i_pc) << (NB_LATCH - NB_REG);
        end
        if (!code_r[5]) begin
            load_word_s = i_reg_data;
        end else begin
            case (code_r)
                CODE_DMEM: load_word_s = i_data_mem_data;
                CODE_IMEM: load_word_s = i_instr_mem_data;
                default:   load_word_s = {NB_REG{1'b0}};
            endcase
        end
        if (from_snap_r) begin
            load_s = snap_r;
        end else begin
            load_s = NB_LATCH'(load_word_s) << (NB_LATCH - NB_REG);
        end
        shifted_s  = shift_r << NB_REG;
        cnt_next_s = cnt_r + NB_CNT'(1);
    end

    // Request FSM with registered frame/strobe/busy outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r       <= IDLE;
            code_r        <= 6'd0;
            reg_addr_r    <= 5'd0;
            dmem_addr_r   <= {NB_ADDR_DATA{1'b0}};
            imem_addr_r   <= {NB_INSTR_ADDR{1'b0}};
            snap_r        <= {NB_LATCH{1'b0}};
            from_snap_r   <= 1'b0;
            shift_r       <= {NB_LATCH{1'b0}};
            words_r       <= {NB_CNT{1'b0}};
            cnt_r         <= {NB_CNT{1'b0}};
            wait_r        <= {NB_WAIT{1'b0}};
            o_frame       <= {NB_REG{1'b0}};
            o_frame_valid <= 1'b0;
            o_eod         <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    o_frame       <= {NB_REG{1'b0}};
                    o_frame_valid <= 1'b0;
                    o_eod         <= 1'b0;
                    if (accept_s) begin
                        code_r      <= i_request_select;
                        reg_addr_r  <= i_request_select[4:0];
                        dmem_addr_r <= i_mem_addr;
                        imem_addr_r <= i_mem_addr[NB_INSTR_ADDR-1:0];
                        snap_r      <= snap_sel_s;
                        from_snap_r <= is_latch_s || (i_request_select == CODE_PC);
                        words_r     <= payload_words(i_request_select);
                        wait_r      <= {NB_WAIT{1'b0}};
                        cnt_r       <= {NB_CNT{1'b0}};
                        o_busy      <= 1'b1;
                        state_r     <= WAIT;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                WAIT: begin
                    if (wait_r == WAIT_LAST) begin
                        shift_r <= load_s;
                        cnt_r   <= {NB_CNT{1'b0}};
                        if (words_r == {NB_CNT{1'b0}}) begin
                            o_eod   <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            o_frame       <= load_s[NB_LATCH-1 -: NB_REG];
                            o_frame_valid <= 1'b1;
                            state_r       <= SEND;
                        end
                    end else begin
                        wait_r <= wait_r + NB_WAIT'(1);
                    end
                end
                SEND: begin
                    cnt_r   <= cnt_next_s;
                    shift_r <= shifted_s;
                    if (cnt_next_s == words_r) begin
                        o_frame       <= {NB_REG{1'b0}};
                        o_frame_valid <= 1'b0;
                        o_eod         <= 1'b1;
                        state_r       <= DONE;
                    end else begin
                        o_frame <= shifted_s[NB_LATCH-1 -: NB_REG];
                    end
                end
                DONE: begin
                    o_eod   <= 1'b0;
                    o_busy  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_debug_frame_server.sv
module tb_mips_debug_frame_server;

    logic         clock = 1'b0;
    logic         reset;
    logic [5:0]   req;
    logic [5:0]   req2;
    logic [15:0]  mem_addr;
    logic [767:0] latch_bus;
    logic [31:0]  pc;
    logic [31:0]  reg_data;
    logic [31:0]  dmem_data;
    logic [31:0]  imem_data;
    logic [31:0]  zero32;
    logic [4:0]   reg_addr;
    logic [15:0]  dmem_addr;
    logic [8:0]   imem_addr;
    logic [31:0]  frame;
    logic         frame_valid, eod, busy;
    logic [4:0]   reg_addr2;
    logic [15:0]  dmem_addr2;
    logic [8:0]   imem_addr2;
    logic [31:0]  frame2;
    logic         frame_valid2, eod2, busy2;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    mips_debug_frame_server dut (
        .i_clock(clock), .i_reset(reset), .i_request_select(req), .i_mem_addr(mem_addr),
        .i_latch_bus(latch_bus), .i_pc(pc), .o_reg_addr(reg_addr), .i_reg_data(reg_data),
        .o_data_mem_addr(dmem_addr), .i_data_mem_data(dmem_data),
        .o_instr_mem_addr(imem_addr), .i_instr_mem_data(imem_data),
        .o_frame(frame), .o_frame_valid(frame_valid), .o_eod(eod), .o_busy(busy)
    );

    mips_debug_frame_server #(.RD_LATENCY(2)) dut2 (
        .i_clock(clock), .i_reset(reset), .i_request_select(req2), .i_mem_addr(mem_addr),
        .i_latch_bus(latch_bus), .i_pc(pc), .o_reg_addr(reg_addr2), .i_reg_data(zero32),
        .o_data_mem_addr(dmem_addr2), .i_data_mem_data(zero32),
        .o_instr_mem_addr(imem_addr2), .i_instr_mem_data(zero32),
        .o_frame(frame2), .o_frame_valid(frame_valid2), .o_eod(eod2), .o_busy(busy2)
    );

    // Read-port models with one cycle of latency.
    always @(posedge clock) begin
        reg_data  <= (reg_addr == 5'd5) ? 32'h12345678 : {27'd0, reg_addr};
        dmem_data <= (dmem_addr == 16'h0010) ? 32'hDEADBEEF : 32'h0;
        imem_data <= (imem_addr == 9'h003) ? 32'hCAFE0003 : 32'h0;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 6'h3F; req2 = 6'h3F;
        repeat (3) tick();
        tests++;
        if ({frame_valid, eod, busy} !== 3'b000 || frame !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got v/e/b=%b frame=%h required 000 00000000", {frame_valid, eod, busy}, frame);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (reg_addr !== 5'd0 || dmem_addr !== 16'h0 || imem_addr !== 9'h0) begin
            fails++;
            $display("FAIL reset_addr: got %h %h %h required 0 0 0", reg_addr, dmem_addr, imem_addr);
        end
        // Reset asserted for three cycles in the middle of a latch stream.
        req = 6'b100100;
        tick();
        req = 6'h3F;
        tick();
        tests++;
        if (frame_valid !== 1'b1 || frame !== 32'hAAAA0001) begin
            fails++;
            $display("FAIL reset_pre_send: got v=%b frame=%h required 1 AAAA0001", frame_valid, frame);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) req = 6'b100100;
            tick();
            tests++;
            if ({frame_valid, eod, busy} !== 3'b000 || frame !== 32'h0) begin
                fails++;
                $display("FAIL reset_mid_send[%0d]: got v/e/b=%b frame=%h required 000 00000000", i, {frame_valid, eod, busy}, frame);
            end
        end
        reset = 1'b0; req = 6'h3F;
        tick();
        tests++;
        if ({frame_valid, eod, busy} !== 3'b000) begin
            fails++;
            $display("FAIL reset_drop_req: got v/e/b=%b required 000", {frame_valid, eod, busy});
        end
    endtask

    task automatic test_latch;
        logic [5:0]  codes [2];
        logic [95:0] grps [2];
        codes[0] = 6'b100100; grps[0] = 96'hAAAA0001_BBBB0002_CCCC0003;
        codes[1] = 6'b101011; grps[1] = 96'h77770001_77770002_77770003;
        for (int c = 0; c < 2; c++) begin
            req = codes[c];
            tick();
            req = 6'h3F;
            latch_bus[95:0] = 96'h0;
            latch_bus[767:672] = 96'h0;
            tests++;
            if (busy !== 1'b1 || frame_valid !== 1'b0) begin
                fails++;
                $display("FAIL latch%0d_t1: got busy=%b v=%b required 1 0", c, busy, frame_valid);
            end
            for (int w = 0; w < 3; w++) begin
                tick();
                tests++;
                if (frame_valid !== 1'b1 || frame !== grps[c][95-32*w -: 32]) begin
                    fails++;
                    $display("FAIL latch%0d_word%0d: got v=%b frame=%h required 1 %h", c, w, frame_valid, frame, grps[c][95-32*w -: 32]);
                end
            end
            tick();
            tests++;
            if ({frame_valid, eod, busy} !== 3'b011 || frame !== 32'h0) begin
                fails++;
                $display("FAIL latch%0d_eod: got v/e/b=%b frame=%h required 011 00000000", c, {frame_valid, eod, busy}, frame);
            end
            tick();
            tests++;
            if ({eod, busy} !== 2'b00) begin
                fails++;
                $display("FAIL latch%0d_idle: got e/b=%b required 00", c, {eod, busy});
            end
            latch_bus[95:0]    = 96'hAAAA0001_BBBB0002_CCCC0003;
            latch_bus[767:672] = 96'h77770001_77770002_77770003;
        end
    endtask

    task automatic test_register;
        req = 6'b000101;
        #1;
        tests++;
        if (reg_addr !== 5'd5) begin
            fails++;
            $display("FAIL reg_addr_t: got %h required 05", reg_addr);
        end
        tick();
        req = 6'h3F;
        #1;
        tests++;
        if (reg_addr !== 5'd5) begin
            fails++;
            $display("FAIL reg_addr_hold: got %h required 05", reg_addr);
        end
        tick();
        tests++;
        if (frame_valid !== 1'b1 || frame !== 32'h12345678) begin
            fails++;
            $display("FAIL reg_frame: got v=%b frame=%h required 1 12345678", frame_valid, frame);
        end
        tick();
        tests++;
        if ({frame_valid, eod} !== 2'b01) begin
            fails++;
            $display("FAIL reg_eod: got v/e=%b required 01", {frame_valid, eod});
        end
        tick();
    endtask

    task automatic test_memory;
        req = 6'b100000; mem_addr = 16'h0010;
        #1;
        tests++;
        if (dmem_addr !== 16'h0010) begin
            fails++;
            $display("FAIL dmem_addr_t: got %h required 0010", dmem_addr);
        end
        tick();
        req = 6'h3F; mem_addr = 16'hFFFF;
        #1;
        tests++;
        if (dmem_addr !== 16'h0010) begin
            fails++;
            $display("FAIL dmem_addr_hold: got %h required 0010", dmem_addr);
        end
        tick();
        tests++;
        if (frame_valid !== 1'b1 || frame !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL dmem_frame: got v=%b frame=%h required 1 DEADBEEF", frame_valid, frame);
        end
        tick();
        tick();
        req = 6'b100001; mem_addr = 16'h0203;
        #1;
        tests++;
        if (imem_addr !== 9'h003) begin
            fails++;
            $display("FAIL imem_addr_t: got %h required 003", imem_addr);
        end
        tick();
        req = 6'h3F; mem_addr = 16'h0000;
        tick();
        tests++;
        if (frame_valid !== 1'b1 || frame !== 32'hCAFE0003) begin
            fails++;
            $display("FAIL imem_frame: got v=%b frame=%h required 1 CAFE0003", frame_valid, frame);
        end
        tick();
        tick();
        // PC snapshot is taken at acceptance.
        req = 6'b100010; pc = 32'h00400010;
        tick();
        req = 6'h3F; pc = 32'h11111111;
        tick();
        tests++;
        if (frame_valid !== 1'b1 || frame !== 32'h00400010) begin
            fails++;
            $display("FAIL pc_frame: got v=%b frame=%h required 1 00400010", frame_valid, frame);
        end
        tick();
        tick();
    endtask

    task automatic test_invalid;
        req = 6'b101100;
        tick();
        req = 6'h3F;
        tests++;
        if ({frame_valid, eod, busy} !== 3'b001) begin
            fails++;
            $display("FAIL invalid_t1: got v/e/b=%b required 001", {frame_valid, eod, busy});
        end
        tick();
        tests++;
        if ({frame_valid, eod, busy} !== 3'b011) begin
            fails++;
            $display("FAIL invalid_eod: got v/e/b=%b required 011", {frame_valid, eod, busy});
        end
        tick();
        tests++;
        if ({frame_valid, eod, busy} !== 3'b000) begin
            fails++;
            $display("FAIL invalid_idle: got v/e/b=%b required 000", {frame_valid, eod, busy});
        end
    endtask

    task automatic test_back_to_back;
        req = 6'b100100;
        tick();
        req = 6'h3F;
        tick();
        tick();
        req = 6'b000101;                    // T+3, busy
        tests++;
        if (frame !== 32'hBBBB0002) begin
            fails++;
            $display("FAIL busy_t3: got frame=%h required BBBB0002", frame);
        end
        tick();
        req = 6'h3F;
        tests++;
        if (frame !== 32'hCCCC0003) begin
            fails++;
            $display("FAIL busy_t4: got frame=%h required CCCC0003", frame);
        end
        tick();
        req = 6'b000101;                    // DONE cycle
        tests++;
        if ({eod, busy} !== 2'b11) begin
            fails++;
            $display("FAIL busy_done: got e/b=%b required 11", {eod, busy});
        end
        tick();
        req = 6'b100010; pc = 32'h00400020; // cycle after DONE
        tests++;
        if ({eod, busy} !== 2'b00) begin
            fails++;
            $display("FAIL busy_done_ignored: got e/b=%b required 00", {eod, busy});
        end
        tick();
        req = 6'h3F;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL next_accept_busy: got %b required 1", busy);
        end
        tick();
        tests++;
        if (frame_valid !== 1'b1 || frame !== 32'h00400020) begin
            fails++;
            $display("FAIL next_accept_frame: got v=%b frame=%h required 1 00400020", frame_valid, frame);
        end
        tick();
        tick();
    endtask

    task automatic test_latency2;
        logic [95:0] grp;
        grp = 96'hAAAA0001_BBBB0002_CCCC0003;
        req2 = 6'b100100;
        tick();
        req2 = 6'h3F;
        tick();
        tests++;
        if (frame_valid2 !== 1'b0 || busy2 !== 1'b1) begin
            fails++;
            $display("FAIL lat2_t2: got v=%b busy=%b required 0 1", frame_valid2, busy2);
        end
        for (int w = 0; w < 3; w++) begin
            tick();
            tests++;
            if (frame_valid2 !== 1'b1 || frame2 !== grp[95-32*w -: 32]) begin
                fails++;
                $display("FAIL lat2_word%0d: got v=%b frame=%h required 1 %h", w, frame_valid2, frame2, grp[95-32*w -: 32]);
            end
        end
        tick();
        tests++;
        if ({frame_valid2, eod2, busy2} !== 3'b011) begin
            fails++;
            $display("FAIL lat2_eod: got v/e/b=%b required 011", {frame_valid2, eod2, busy2});
        end
        tick();
    endtask

    initial begin
        zero32    = 32'h0;
        mem_addr  = 16'h0;
        pc        = 32'h0;
        latch_bus = '0;
        for (int k = 1; k < 7; k++) latch_bus[k*96 +: 96] = {3{24'h5A5A00, 8'(k)}};
        latch_bus[95:0]    = 96'hAAAA0001_BBBB0002_CCCC0003;
        latch_bus[767:672] = 96'h77770001_77770002_77770003;
        test_reset();
        test_latch();
        test_register();
        test_memory();
        test_invalid();
        test_back_to_back();
        test_latency2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
